// File: rtl/eth_rx_payload_fifo_if.sv
// Byte-stream bundle between the MAC RX side / payload consumer and the
// receive payload FIFO: MAC bytes flow in, committed payload bytes flow out.
interface eth_rx_payload_fifo_if;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic       i_rx_last;
    logic       i_rx_err;
    logic [7:0] o_rdata;
    logic       o_rready;
    logic       i_rreq;

    modport master (
        output i_rx_data, i_rx_valid, i_rx_last, i_rx_err, i_rreq,
        input  o_rdata, o_rready
    );

    modport slave (
        input  i_rx_data, i_rx_valid, i_rx_last, i_rx_err, i_rreq,
        output o_rdata, o_rready
    );
endinterface

// File: rtl/eth_rx_payload_fifo.sv
// Ethernet RX frame filter (dst MAC + EtherType) and frame-atomic payload FIFO.
// Payload becomes visible to the reader only once its frame ends cleanly.
module eth_rx_payload_fifo #(
    parameter int          ADDR_W      = 10,
    parameter logic [47:0] MY_MAC      = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int          MAX_PAYLOAD = 1500
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    eth_rx_payload_fifo_if.slave       bus,
    output logic [15:0]                o_frm_cnt,
    output logic [15:0]                o_drop_cnt
);

    typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_DISCARD} state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [10:0]       MAX_PLEN = 11'(MAX_PAYLOAD);

    state_t            state;
    logic [3:0]        hcnt;
    logic [10:0]       plen;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] wr_commit;
    logic [ADDR_W-1:0] rd_ptr;
    logic              mac_ok, bc_ok, et_ok;
    logic [7:0]        mem [2**ADDR_W];

    logic [ADDR_W-1:0] wr_next;
    logic              rready;
    logic              overflow;
    logic              wr_en;
    logic [7:0]        exp_byte;
    logic              is_mac, is_et;
    logic              mac_ok_n, bc_ok_n, et_ok_n, pass_n;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign wr_next  = wr_ptr + PTR_ONE;
    assign rready   = (wr_commit != rd_ptr);
    // Full is judged against rd_ptr before any same-cycle pop, which is conservative.
    assign overflow = (wr_next == rd_ptr) || (plen == MAX_PLEN);
    assign wr_en    = (state == S_PAYLOAD) && bus.i_rx_valid && !overflow &&
                      !(bus.i_rx_last && bus.i_rx_err);

    assign bus.o_rready = rready;
    assign bus.o_rdata  = rready ? mem[rd_ptr] : 8'h00;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        exp_byte = 8'h00;
        case (hcnt)
            4'd0:    exp_byte = MY_MAC[47:40];
            4'd1:    exp_byte = MY_MAC[39:32];
            4'd2:    exp_byte = MY_MAC[31:24];
            4'd3:    exp_byte = MY_MAC[23:16];
            4'd4:    exp_byte = MY_MAC[15:8];
            4'd5:    exp_byte = MY_MAC[7:0];
            4'd12:   exp_byte = ETHERTYPE[15:8];
            4'd13:   exp_byte = ETHERTYPE[7:0];
            default: exp_byte = 8'h00;
        endcase
    end

    assign is_mac   = (hcnt < 4'd6);
    assign is_et    = (hcnt >= 4'd12);
    assign mac_ok_n = mac_ok && (!is_mac || (bus.i_rx_data == exp_byte));
    assign bc_ok_n  = bc_ok  && (!is_mac || (bus.i_rx_data == 8'hFF));
    assign et_ok_n  = et_ok  && (!is_et  || (bus.i_rx_data == exp_byte));
    assign pass_n   = (mac_ok_n || bc_ok_n) && et_ok_n;

    // NOTE: payload storage has no reset; the pointers alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr] <= bus.i_rx_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_HDR;
            hcnt       <= 4'd0;
            plen       <= 11'd0;
            wr_ptr     <= '0;
            wr_commit  <= '0;
            rd_ptr     <= '0;
            mac_ok     <= 1'b1;
            bc_ok      <= 1'b1;
            et_ok      <= 1'b1;
            o_frm_cnt  <= 16'd0;
            o_drop_cnt <= 16'd0;
        end else begin
            if (bus.i_rreq && rready) rd_ptr <= rd_ptr + PTR_ONE;

            if (bus.i_rx_valid) begin
                case (state)
                    S_HDR: begin
                        if (bus.i_rx_last || hcnt == 4'd13) begin
                            hcnt   <= 4'd0;
                            plen   <= 11'd0;
                            mac_ok <= 1'b1;
                            bc_ok  <= 1'b1;
                            et_ok  <= 1'b1;
                            if (bus.i_rx_last) begin
                                // A frame that ends on its EtherType byte matched but had no room for payload.
                                state <= S_HDR;
                                if (hcnt == 4'd13 && pass_n) o_drop_cnt <= sat_inc(o_drop_cnt);
                            end else begin
                                state <= pass_n ? S_PAYLOAD : S_DISCARD;
                            end
                        end else begin
                            hcnt   <= hcnt + 4'd1;
                            mac_ok <= mac_ok_n;
                            bc_ok  <= bc_ok_n;
                            et_ok  <= et_ok_n;
                        end
                    end

                    S_PAYLOAD: begin
                        if (overflow) begin
                            wr_ptr     <= wr_commit;
                            o_drop_cnt <= sat_inc(o_drop_cnt);
                            state      <= bus.i_rx_last ? S_HDR : S_DISCARD;
                        end else if (bus.i_rx_last) begin
                            state <= S_HDR;
                            if (bus.i_rx_err) begin
                                wr_ptr     <= wr_commit;
                                o_drop_cnt <= sat_inc(o_drop_cnt);
                            end else begin
                                wr_ptr    <= wr_next;
                                wr_commit <= wr_next;
                                o_frm_cnt <= sat_inc(o_frm_cnt);
                            end
                        end else begin
                            wr_ptr <= wr_next;
                            plen   <= plen + 11'd1;
                        end
                    end

                    S_DISCARD: begin
                        if (bus.i_rx_last) state <= S_HDR;
                    end

                    default: state <= S_HDR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_payload_fifo.sv
// Directed bench: filtering, commit/pop timing, error/overflow/oversize drops,
// wrap-around with a concurrent reader, and mid-frame reset.
module tb_eth_rx_payload_fifo;

    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MYMAC = 48'h02_00_00_00_00_01;
    localparam logic [15:0] ET    = 16'h88B5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_last = 1'b0;
    logic        rx_err = 1'b0;
    logic        use_b = 1'b0;
    logic        rreq_a = 1'b0;
    logic        rreq_b = 1'b0;
    logic [15:0] frm_a, drop_a, frm_b, drop_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    eth_rx_payload_fifo_if if_a ();
    eth_rx_payload_fifo_if if_b ();

    assign if_a.i_rx_data  = rx_data;
    assign if_a.i_rx_valid = rx_valid & ~use_b;
    assign if_a.i_rx_last  = rx_last;
    assign if_a.i_rx_err   = rx_err;
    assign if_a.i_rreq     = rreq_a;
    assign if_b.i_rx_data  = rx_data;
    assign if_b.i_rx_valid = rx_valid & use_b;
    assign if_b.i_rx_last  = rx_last;
    assign if_b.i_rx_err   = rx_err;
    assign if_b.i_rreq     = rreq_b;

    // Small FIFO for overflow/wrap work.
    eth_rx_payload_fifo #(.ADDR_W(4)) dut_a (
        .i_clk      (clk),
        .i_rst      (rst),
        .bus        (if_a),
        .o_frm_cnt  (frm_a),
        .o_drop_cnt (drop_a)
    );

    // Roomy FIFO with a short payload limit for the oversize boundary.
    eth_rx_payload_fifo #(.ADDR_W(6), .MAX_PAYLOAD(12)) dut_b (
        .i_clk      (clk),
        .i_rst      (rst),
        .bus        (if_b),
        .o_frm_cnt  (frm_b),
        .o_drop_cnt (drop_b)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hdr_byte(input logic [47:0] dst, input logic [15:0] et, input int i);
        if (i < 6)       return dst[8*(5-i) +: 8];
        else if (i < 12) return 8'(8'h30 + i);
        else if (i == 12) return et[15:8];
        else             return et[7:0];
    endfunction

    // Presents one byte for exactly one rising edge; called and returns at a falling edge.
    task automatic put(input logic [7:0] d, input logic last, input logic err);
        rx_data  = d;
        rx_valid = 1'b1;
        rx_last  = last;
        rx_err   = err;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_err   = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input int len,
                              input logic [7:0] base, input logic err, input bit gap);
        for (int i = 0; i < 14; i++) begin
            put(hdr_byte(dst, et, i), (len == 0) && (i == 13), 1'b0);
            if (gap && (i % 4 == 3)) @(negedge clk);
        end
        for (int i = 0; i < len; i++) begin
            put(8'(base + i), i == len - 1, err && (i == len - 1));
            if (gap && (i % 3 == 1)) @(negedge clk);
        end
    endtask

    task automatic hdr_only(input int n);
        for (int i = 0; i < n; i++) put(hdr_byte(BCAST, ET, i), i == n - 1, 1'b0);
    endtask

    task automatic pop_a(input string tag, input logic [7:0] exp);
        check(tag, {8'h00, if_a.o_rdata}, {8'h00, exp});
        rreq_a = 1'b1;
        @(negedge clk);
        rreq_a = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_rready", {15'd0, if_a.o_rready}, 16'd0);
        check("rst_rdata",  {8'h00, if_a.o_rdata}, 16'h0000);
        check("rst_frm",    frm_a, 16'd0);
        check("rst_drop",   drop_a, 16'd0);

        // Good broadcast frame: visible the cycle after its last byte.
        send_frame(BCAST, ET, 3, 8'h01, 1'b0, 1'b0);
        check("good_rready", {15'd0, if_a.o_rready}, 16'd1);
        pop_a("good_b0", 8'h01);
        pop_a("good_b1", 8'h02);
        pop_a("good_b2", 8'h03);
        check("good_empty", {15'd0, if_a.o_rready}, 16'd0);
        check("good_rdata0", {8'h00, if_a.o_rdata}, 16'h0000);
        check("good_frm", frm_a, 16'd1);

        // Filtering: wrong unicast dst, wrong EtherType.
        send_frame(48'h02_00_00_00_00_02, ET, 4, 8'h90, 1'b0, 1'b0);
        check("flt_mac_rready", {15'd0, if_a.o_rready}, 16'd0);
        send_frame(BCAST, 16'h0800, 4, 8'h90, 1'b0, 1'b0);
        check("flt_et_rready", {15'd0, if_a.o_rready}, 16'd0);
        check("flt_frm", frm_a, 16'd1);
        check("flt_drop", drop_a, 16'd0);

        // Own unicast address accepted.
        send_frame(MYMAC, ET, 2, 8'h50, 1'b0, 1'b0);
        check("uni_frm", frm_a, 16'd2);
        pop_a("uni_b0", 8'h50);
        pop_a("uni_b1", 8'h51);

        // Error frame dropped; next frame commits alone.
        send_frame(BCAST, ET, 10, 8'h60, 1'b1, 1'b0);
        check("err_rready", {15'd0, if_a.o_rready}, 16'd0);
        check("err_drop", drop_a, 16'd1);
        send_frame(BCAST, ET, 1, 8'hAA, 1'b0, 1'b0);
        check("after_err_frm", frm_a, 16'd3);
        pop_a("after_err_b0", 8'hAA);
        check("after_err_empty", {15'd0, if_a.o_rready}, 16'd0);

        // Header-only frames: ending on byte 13 counts a drop, earlier does not.
        hdr_only(14);
        check("hdr14_drop", drop_a, 16'd2);
        hdr_only(6);
        check("hdr6_drop", drop_a, 16'd2);
        send_frame(BCAST, ET, 1, 8'h77, 1'b0, 1'b0);
        pop_a("after_hdr_b0", 8'h77);
        check("after_hdr_frm", frm_a, 16'd4);

        // Overflow: 10 committed bytes (straddling the wrap), then an 8-byte frame that cannot fit.
        send_frame(BCAST, ET, 10, 8'h20, 1'b0, 1'b0);
        check("ovf_frm", frm_a, 16'd5);
        send_frame(BCAST, ET, 8, 8'h40, 1'b0, 1'b0);
        check("ovf_drop", drop_a, 16'd3);
        check("ovf_frm_hold", frm_a, 16'd5);
        for (int i = 0; i < 10; i++) pop_a("ovf_readback", 8'(8'h20 + i));
        check("ovf_empty", {15'd0, if_a.o_rready}, 16'd0);

        // Oversize boundary on the second instance: 12 bytes fit, 13 do not.
        use_b = 1'b1;
        send_frame(BCAST, ET, 12, 8'hC0, 1'b0, 1'b0);
        check("max_frm", frm_b, 16'd1);
        send_frame(BCAST, ET, 13, 8'hD0, 1'b0, 1'b0);
        check("oversize_drop", drop_b, 16'd1);
        check("oversize_frm", frm_b, 16'd1);
        use_b = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("max_readback", {8'h00, if_b.o_rdata}, {8'h00, 8'(8'hC0 + i)});
            rreq_b = 1'b1;
            @(negedge clk);
            rreq_b = 1'b0;
        end
        check("max_empty", {15'd0, if_b.o_rready}, 16'd0);

        // Wrap and concurrency from a fresh reset: gapped writer, continuous reader.
        do_reset();
        check("rst2_frm", frm_a, 16'd0);
        check("rst2_drop", drop_a, 16'd0);
        fork
            begin
                for (int f = 0; f < 20; f++) send_frame(BCAST, ET, 7, 8'(8'h80 + f * 7), 1'b0, 1'b1);
            end
            begin
                int k;
                int cyc;
                k = 0;
                cyc = 0;
                while (k < 140 && cyc < 3000) begin
                    if (if_a.o_rready) begin
                        check("wrap_data", {8'h00, if_a.o_rdata}, {8'h00, 8'(8'h80 + k)});
                        rreq_a = 1'b1;
                        k++;
                    end else begin
                        rreq_a = 1'b0;
                    end
                    @(negedge clk);
                    cyc++;
                end
                rreq_a = 1'b0;
                check("wrap_count", 16'(k), 16'd140);
            end
        join
        check("wrap_frm", frm_a, 16'd20);
        check("wrap_drop", drop_a, 16'd0);
        check("wrap_empty", {15'd0, if_a.o_rready}, 16'd0);

        // Mid-frame reset: committed frame 1 and partial frame 2 are both lost.
        send_frame(BCAST, ET, 4, 8'h11, 1'b0, 1'b0);
        check("mid_f1_rready", {15'd0, if_a.o_rready}, 16'd1);
        for (int i = 0; i < 14; i++) put(hdr_byte(BCAST, ET, i), 1'b0, 1'b0);
        put(8'h31, 1'b0, 1'b0);
        put(8'h32, 1'b0, 1'b0);
        rx_data  = 8'h33;
        rx_valid = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rst      = 1'b0;
        check("mid_rready", {15'd0, if_a.o_rready}, 16'd0);
        check("mid_rdata", {8'h00, if_a.o_rdata}, 16'h0000);
        check("mid_frm", frm_a, 16'd0);
        check("mid_drop", drop_a, 16'd0);
        send_frame(BCAST, ET, 3, 8'h61, 1'b0, 1'b0);
        pop_a("mid_after_b0", 8'h61);
        pop_a("mid_after_b1", 8'h62);
        pop_a("mid_after_b2", 8'h63);
        check("mid_after_empty", {15'd0, if_a.o_rready}, 16'd0);
        check("mid_after_frm", frm_a, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
